// File: rtl/pipelined_seg_adder.sv
// Pipelined segmented ripple-carry adder/subtractor. Each stage ripples one SEG-bit
// segment; operands skew forward and partial sums deskew behind a valid/ready handshake.
module pipelined_seg_adder #(
    parameter int WIDTH = 80,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSTAGE = WIDTH / SEG;

    logic              en;
    logic [WIDTH-1:0]  be;
    logic              c0;
    logic [NSTAGE-1:0] valid_q;

    assign be        = sub ? ~b : b;
    assign c0        = sub ? 1'b1 : cin;
    assign en        = !valid_q[NSTAGE-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = valid_q[NSTAGE-1];

    // Valid bits shift in lockstep with the data; en=0 freezes the whole pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= '0;
        else if (en)
            valid_q <= (valid_q << 1) | NSTAGE'(in_valid);
    end

    // Intermediate stages: each keeps only the operand bits still to be added
    // and the sum bits already produced, so register widths shrink/grow per stage.
    for (genvar k = 0; k < NSTAGE - 1; k++) begin : g_mid
        localparam int HI = (k + 1) * SEG;

        logic [WIDTH-1:k*SEG] a_src;
        logic [WIDTH-1:k*SEG] b_src;
        logic                 c_src;
        logic [SEG:0]         seg;
        logic [HI-1:0]        s_next;
        logic [WIDTH-1:HI]    a_q;
        logic [WIDTH-1:HI]    b_q;
        logic [HI-1:0]        s_q;
        logic                 c_q;

        if (k == 0) begin : g_first
            assign a_src  = a;
            assign b_src  = be;
            assign c_src  = c0;
            assign s_next = seg[SEG-1:0];
        end else begin : g_next
            assign a_src  = g_mid[k-1].a_q;
            assign b_src  = g_mid[k-1].b_q;
            assign c_src  = g_mid[k-1].c_q;
            assign s_next = {seg[SEG-1:0], g_mid[k-1].s_q};
        end

        assign seg = {1'b0, a_src[k*SEG +: SEG]} + {1'b0, b_src[k*SEG +: SEG]}
                   + (SEG+1)'(c_src);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (en) begin
                a_q <= a_src[WIDTH-1:HI];
                b_q <= b_src[WIDTH-1:HI];
                s_q <= s_next;
                c_q <= seg[SEG];
            end
        end
    end

    logic [SEG-1:0]   fin_a;
    logic [SEG-1:0]   fin_b;
    logic             fin_c;
    logic [SEG:0]     fin_seg;
    logic [WIDTH-1:0] sum_next;

    if (NSTAGE == 1) begin : g_single
        assign fin_a    = a;
        assign fin_b    = be;
        assign fin_c    = c0;
        assign sum_next = fin_seg[SEG-1:0];
    end else begin : g_last
        assign fin_a    = g_mid[NSTAGE-2].a_q;
        assign fin_b    = g_mid[NSTAGE-2].b_q;
        assign fin_c    = g_mid[NSTAGE-2].c_q;
        assign sum_next = {fin_seg[SEG-1:0], g_mid[NSTAGE-2].s_q};
    end

    assign fin_seg = {1'b0, fin_a} + {1'b0, fin_b} + (SEG+1)'(fin_c);

    // Final stage drives the outputs straight from registers; overflow uses the
    // top operand bits that travelled along with the op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (en) begin
            sum  <= sum_next;
            cout <= fin_seg[SEG];
            ovf  <= (fin_a[SEG-1] == fin_b[SEG-1]) && (sum_next[WIDTH-1] != fin_a[SEG-1]);
        end
    end

endmodule

// File: tb/tb_pipelined_seg_adder.sv
// Self-checking bench for pipelined_seg_adder: directed corner cases and randomized
// backpressure traffic against an arithmetic reference model, on three parameter sets.
module tb_pipelined_seg_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   check_count = 0;
    int   error_count = 0;
    int   cycle = 0;
    int   pop_count = 0;

    always #5 clk = ~clk;

    logic        in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0, cout0, ovf0;
    logic [79:0] a0, b0, sum0;
    logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
    logic [31:0] a1, b1, sum1;
    logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
    logic [15:0] a2, b2, sum2;

    pipelined_seg_adder #(.WIDTH(80), .SEG(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .cin(cin0), .sub(sub0), .out_valid(out_valid0),
        .out_ready(out_ready0), .sum(sum0), .cout(cout0), .ovf(ovf0));

    pipelined_seg_adder #(.WIDTH(32), .SEG(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1));

    pipelined_seg_adder #(.WIDTH(16), .SEG(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2));

    typedef struct packed {
        logic [79:0] sum;
        logic        cout;
        logic        ovf;
        int          acc_cycle;
    } exp_t;

    exp_t exp_q[$];

    logic        stalled = 1'b0;
    logic        hold_valid, hold_cout, hold_ovf;
    logic [79:0] hold_sum;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: true modular sum/difference, unsigned carry and signed range test.
    function automatic exp_t refModel(input int w, input logic [79:0] av, input logic [79:0] bv,
                                      input logic cv, input logic sv);
        logic [127:0]        mod_v, full;
        logic signed [127:0] sa, sb, res, half;
        exp_t                r;
        mod_v = 128'd1 << w;
        half  = $signed(mod_v >> 1);
        full  = sv ? ({48'd0, av} + mod_v - {48'd0, bv})
                   : ({48'd0, av} + {48'd0, bv} + {127'd0, cv});
        sa = $signed({48'd0, av});
        sb = $signed({48'd0, bv});
        if (sa >= half) sa = sa - $signed(mod_v);
        if (sb >= half) sb = sb - $signed(mod_v);
        res = sv ? (sa - sb) : (sa + sb + $signed({127'd0, cv}));
        r.sum       = 80'(full & (mod_v - 128'd1));
        r.cout      = (full >= mod_v);
        r.ovf       = (res >= half) || (res < -half);
        r.acc_cycle = 0;
        return r;
    endfunction

    // One cycle on the 80-bit instance: called at a falling edge, drives inputs,
    // scores any pop against the queue and records stall snapshots.
    task automatic applyStimulus(input logic iv, input logic [79:0] av, input logic [79:0] bv,
                                 input logic cv, input logic sv, input logic ordy,
                                 input exp_t e, input logic lat_chk, output logic accepted);
        exp_t head;
        if (stalled) begin
            checkOutput("stall_valid", out_valid0, hold_valid);
            checkOutput("stall_sum", sum0, hold_sum);
            checkOutput("stall_cout", cout0, hold_cout);
            checkOutput("stall_ovf", ovf0, hold_ovf);
        end
        in_valid0  = iv;
        a0         = av;
        b0         = bv;
        cin0       = cv;
        sub0       = sv;
        out_ready0 = ordy;
        #1;
        checkOutput("in_ready", in_ready0, !out_valid0 || ordy);
        accepted = iv && (!out_valid0 || ordy);
        if (out_valid0 && ordy) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_out", out_valid0, 1'b0);
            end else begin
                head = exp_q.pop_front();
                checkOutput("sum", sum0, head.sum);
                checkOutput("cout", cout0, head.cout);
                checkOutput("ovf", ovf0, head.ovf);
                if (lat_chk) checkOutput("latency", cycle - head.acc_cycle, 5);
                pop_count++;
            end
        end
        if (accepted) begin
            e.acc_cycle = cycle;
            exp_q.push_back(e);
        end
        stalled    = out_valid0 && !ordy;
        hold_valid = out_valid0;
        hold_sum   = sum0;
        hold_cout  = cout0;
        hold_ovf   = ovf0;
        @(negedge clk);
        cycle++;
    endtask

    task automatic drainIdle(input int max_cycles, input logic lat_chk);
        exp_t dummy;
        logic acc;
        dummy = '0;
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, dummy, lat_chk, acc);
        checkOutput("drain_empty", exp_q.size(), 0);
    endtask

    task automatic runDirected(input logic [79:0] av, input logic [79:0] bv, input logic cv,
                               input logic sv, input logic [79:0] es, input logic ec,
                               input logic eo);
        exp_t e;
        logic acc;
        e.sum       = es;
        e.cout      = ec;
        e.ovf       = eo;
        e.acc_cycle = 0;
        applyStimulus(1'b1, av, bv, cv, sv, 1'b1, e, 1'b1, acc);
        drainIdle(20, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e, 1'b1, acc);
    endtask

    // Single op through one of the narrow instances, measuring latency to out_valid.
    task automatic runSmall(input int sel, input logic [79:0] av, input logic [79:0] bv,
                            input logic cv, input logic sv, input exp_t e, input int exp_lat);
        int          lat;
        string       pfx;
        logic        vld;
        logic [79:0] s;
        logic        co, ov;
        pfx = (sel == 1) ? "w32" : "w16";
        if (sel == 1) begin
            in_valid1 = 1'b1; a1 = av[31:0]; b1 = bv[31:0]; cin1 = cv; sub1 = sv;
        end else begin
            in_valid2 = 1'b1; a2 = av[15:0]; b2 = bv[15:0]; cin2 = cv; sub2 = sv;
        end
        #1;
        checkOutput({pfx, "_in_ready"}, (sel == 1) ? in_ready1 : in_ready2, 1'b1);
        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        lat = 1;
        vld = (sel == 1) ? out_valid1 : out_valid2;
        while (!vld && lat < 12) begin
            @(negedge clk);
            lat++;
            vld = (sel == 1) ? out_valid1 : out_valid2;
        end
        s  = (sel == 1) ? {48'd0, sum1} : {64'd0, sum2};
        co = (sel == 1) ? cout1 : cout2;
        ov = (sel == 1) ? ovf1 : ovf2;
        checkOutput({pfx, "_latency"}, lat, exp_lat);
        checkOutput({pfx, "_sum"}, s, e.sum);
        checkOutput({pfx, "_cout"}, co, e.cout);
        checkOutput({pfx, "_ovf"}, ov, e.ovf);
        @(negedge clk);
        checkOutput({pfx, "_popped"}, (sel == 1) ? out_valid1 : out_valid2, 1'b0);
    endtask

    initial begin
        exp_t        e;
        logic        acc, have, ordy;
        logic [95:0] ra, rb;
        logic        rc, rs;
        int          n_acc;

        rst_n = 1'b0;
        in_valid0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0; out_ready0 = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;
        #2;
        checkOutput("rst_out_valid", out_valid0, 1'b0);
        checkOutput("rst_sum", sum0, 80'd0);
        checkOutput("rst_cout", cout0, 1'b0);
        checkOutput("rst_ovf", ovf0, 1'b0);
        checkOutput("rst_in_ready", in_ready0, 1'b1);
        checkOutput("rst_w32_valid", out_valid1, 1'b0);
        checkOutput("rst_w16_valid", out_valid2, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed corner cases");
        runDirected({80{1'b1}}, 80'd0, 1'b1, 1'b0, 80'd0, 1'b1, 1'b0);
        runDirected(80'd5, 80'd7, 1'b0, 1'b1, {{79{1'b1}}, 1'b0}, 1'b0, 1'b0);
        runDirected(80'd7, 80'd5, 1'b0, 1'b1, 80'd2, 1'b1, 1'b0);
        runDirected(80'd7, 80'd5, 1'b1, 1'b1, 80'd2, 1'b1, 1'b0);
        runDirected({1'b0, {79{1'b1}}}, 80'd1, 1'b0, 1'b0, {1'b1, 79'd0}, 1'b0, 1'b1);
        runDirected({1'b1, 79'd0}, 80'd1, 1'b0, 1'b1, {1'b0, {79{1'b1}}}, 1'b1, 1'b1);

        $display("[TB] random traffic with backpressure");
        pop_count = 0;
        n_acc = 0;
        have = 1'b0;
        ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
        for (int i = 0; i < 400 && pop_count < 20; i++) begin
            if (!have && n_acc < 20) begin
                ra   = {$urandom(), $urandom(), $urandom()};
                rb   = {$urandom(), $urandom(), $urandom()};
                rc   = 1'($urandom_range(0, 1));
                rs   = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            e    = refModel(80, ra[79:0], rb[79:0], rc, rs);
            ordy = 1'($urandom_range(0, 1));
            applyStimulus(have, ra[79:0], rb[79:0], rc, rs, ordy, e, 1'b0, acc);
            if (acc) begin
                have = 1'b0;
                n_acc++;
            end
        end
        checkOutput("bp_accepted", n_acc, 20);
        checkOutput("bp_popped", pop_count, 20);
        checkOutput("bp_queue_empty", exp_q.size(), 0);
        drainIdle(5, 1'b0);

        $display("[TB] reset while ops are in flight");
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom(), $urandom(), $urandom()} | 96'h1;
            e  = refModel(80, ra[79:0], 80'd0, 1'b0, 1'b0);
            applyStimulus(1'b1, ra[79:0], 80'd0, 1'b0, 1'b0, 1'b1, e, 1'b0, acc);
        end
        e = '0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e, 1'b0, acc);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e, 1'b0, acc);
        checkOutput("pre_reset_valid", out_valid0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid0, 1'b0);
        checkOutput("mid_rst_sum", sum0, 80'd0);
        checkOutput("mid_rst_cout", cout0, 1'b0);
        checkOutput("mid_rst_ovf", ovf0, 1'b0);
        checkOutput("mid_rst_in_ready", in_ready0, 1'b1);
        exp_q.delete();
        stalled = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        cycle += 2;
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e, 1'b0, acc);
        checkOutput("post_rst_idle_valid", out_valid0, 1'b0);
        runDirected(80'h1234_5678_9ABC_DEF0_1357, 80'h0000_0000_0000_0000_0001, 1'b0, 1'b0,
                    80'h1234_5678_9ABC_DEF0_1358, 1'b0, 1'b0);

        $display("[TB] alternate parameter sets");
        e.sum = 80'h0101_0000; e.cout = 1'b0; e.ovf = 1'b0; e.acc_cycle = 0;
        runSmall(1, 80'h00FF_00FF, 80'h0001_FF01, 1'b0, 1'b0, e, 4);
        e.sum = 80'h0101; e.cout = 1'b0; e.ovf = 1'b0;
        runSmall(2, 80'h00FF, 80'h0001, 1'b1, 1'b0, e, 1);
        for (int i = 0; i < 3; i++) begin
            ra = {64'd0, $urandom()};
            rb = {64'd0, $urandom()};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            runSmall(1, ra[79:0], rb[79:0], rc, rs, refModel(32, ra[79:0], rb[79:0], rc, rs), 4);
            ra = {80'd0, ra[15:0]};
            rb = {80'd0, rb[15:0]};
            runSmall(2, ra[79:0], rb[79:0], rc, rs, refModel(16, ra[79:0], rb[79:0], rc, rs), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

endmodule
